// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, last round constant, word/block types
// and the small word/byte helpers used by the key schedule.
package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_LAST = 8'h36;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic {
        KS_IDLE,
        KS_EMIT
    } ks_state_t;

    // Division by x in GF(2^8): steps the round constant back by one round.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Key-load / round-key stream bundle between the loader, the reverse key
// schedule and the inverse-round datapath.
interface aes_inv_key_sched_if;
    import aes_pkg::*;

    logic       start;
    block_t     key_last;
    logic       busy;
    logic       rk_valid;
    logic       rk_ready;
    block_t     rk_data;
    logic [3:0] rk_round;
    logic       done;

    modport master (
        output start, key_last, rk_ready,
        input  busy, rk_valid, rk_data, rk_round, done
    );

    modport slave (
        input  start, key_last, rk_ready,
        output busy, rk_valid, rk_data, rk_round, done
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: loaded with the round-NR key, streams round
// keys NR..0 over a valid/ready handshake, deriving each from the one before.
module aes_inv_key_sched #(
    parameter int         NR        = aes_pkg::AES_NR,
    parameter logic [7:0] RCON_LAST = aes_pkg::RCON_LAST
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_key_sched_if.slave   kif
);
    import aes_pkg::word_t;
    import aes_pkg::block_t;
    import aes_pkg::ks_state_t;
    import aes_pkg::KS_IDLE;
    import aes_pkg::KS_EMIT;
    import aes_pkg::inv_xtime;
    import aes_pkg::rot_word;

    ks_state_t  state_reg;
    block_t     rk_data_reg;
    logic [3:0] rk_round_reg;
    logic [7:0] rcon_reg;
    logic       rk_valid_reg;
    logic       busy_reg;
    logic       done_reg;

    word_t  w0, w1, w2, w3;
    word_t  p0, p1, p2, p3;
    word_t  rot_p3;
    word_t  sub_p3;
    block_t prev_key;
    logic   accept;

    assign w0 = rk_data_reg[127:96];
    assign w1 = rk_data_reg[95:64];
    assign w2 = rk_data_reg[63:32];
    assign w3 = rk_data_reg[31:0];

    // Undo w[i] = w[i-1] ^ w[i-4] for the three plain words of the round.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rot_p3 = rot_word(p3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .a (rot_p3[gi*8 +: 8]),
                .y (sub_p3[gi*8 +: 8])
            );
        end
    endgenerate

    assign p0       = w0 ^ sub_p3 ^ {rcon_reg, 24'h0};
    assign prev_key = {p0, p1, p2, p3};
    assign accept   = rk_valid_reg && kif.rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= KS_IDLE;
            rk_data_reg  <= '0;
            rk_round_reg <= '0;
            rcon_reg     <= RCON_LAST;
            rk_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                KS_IDLE: begin
                    if (kif.start) begin
                        rk_data_reg  <= kif.key_last;
                        rk_round_reg <= 4'(NR);
                        rcon_reg     <= RCON_LAST;
                        rk_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= KS_EMIT;
                    end
                end
                KS_EMIT: begin
                    // Outputs only move on an accepted key; start is ignored here.
                    if (accept) begin
                        if (rk_round_reg != 4'd0) begin
                            rk_data_reg  <= prev_key;
                            rk_round_reg <= rk_round_reg - 4'd1;
                            rcon_reg     <= inv_xtime(rcon_reg);
                        end else begin
                            rk_valid_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= KS_IDLE;
                        end
                    end
                end
                default: state_reg <= KS_IDLE;
            endcase
        end
    end

    assign kif.busy     = busy_reg;
    assign kif.rk_valid = rk_valid_reg;
    assign kif.rk_data  = rk_data_reg;
    assign kif.rk_round = rk_round_reg;
    assign kif.done     = done_reg;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for the reverse key schedule: expected keys come from a forward
// FIPS-197 key expansion with an S-box built from GF(2^8) inversion.
module tb_aes_inv_key_sched;

    logic clk;
    logic rst_n;

    aes_inv_key_sched_if kif ();

    aes_inv_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb     [256];
    logic [127:0] exp_rk [11];
    logic [7:0]   exp_rc [11];
    logic [127:0] obs_rk [11];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128 key expansion from the cipher key (round 0).
    task automatic expand(input logic [127:0] key0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key0[127 - 32*i -: 32];
        rc = 8'h01;
        exp_rc[0] = 8'h00;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                exp_rc[i/4] = rc;
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full load-and-drain; optional stall round, stray start round, reset round.
    task automatic run_seq(input string name, input logic [127:0] key,
                           input int stall_round, input int inj_round, input int rst_round);
        int r;
        int stall;
        int guard;
        logic acc;
        kif.key_last = key;
        kif.rk_ready = 1'b1;
        kif.start    = 1'b1;
        tick();
        kif.start = 1'b0;
        check($sformatf("%s_busy_on", name), {127'b0, kif.busy}, 128'd1);
        r = 10;
        stall = 3;
        guard = 0;
        while (r >= 0 && guard < 40) begin
            guard++;
            check($sformatf("%s_r%0d_valid", name, r), {127'b0, kif.rk_valid}, 128'd1);
            check($sformatf("%s_r%0d_round", name, r), {124'b0, kif.rk_round}, 128'(r));
            check($sformatf("%s_r%0d_data", name, r), kif.rk_data, exp_rk[r]);
            if (r >= 1)
                check($sformatf("%s_r%0d_rcon", name, r), {120'b0, dut.rcon_reg}, {120'b0, exp_rc[r]});
            obs_rk[r] = kif.rk_data;
            if (r == rst_round) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("%s_rst_valid", name), {127'b0, kif.rk_valid}, 128'd0);
                check($sformatf("%s_rst_busy", name), {127'b0, kif.busy}, 128'd0);
                check($sformatf("%s_rst_round", name), {124'b0, kif.rk_round}, 128'd0);
                check($sformatf("%s_rst_data", name), kif.rk_data, 128'd0);
                @(negedge clk);
                rst_n = 1'b1;
                $display("%s: reset at round %0d", name, r);
                return;
            end
            if (r == stall_round && stall > 0) begin
                kif.rk_ready = 1'b0;
                stall--;
            end else begin
                kif.rk_ready = 1'b1;
            end
            if (r == inj_round) begin
                kif.start    = 1'b1;
                kif.key_last = ~key;
            end
            if (r == 0) kif.start = 1'b1;
            acc = kif.rk_ready;
            tick();
            kif.start    = 1'b0;
            kif.key_last = key;
            if (acc) begin
                $display("%s: key r=%0d %h", name, r, obs_rk[r]);
                r--;
            end
        end
        check($sformatf("%s_timeout", name), 128'(r), 128'(-1));
        check($sformatf("%s_done_pulse", name), {127'b0, kif.done}, 128'd1);
        check($sformatf("%s_busy_off", name), {127'b0, kif.busy}, 128'd0);
        check($sformatf("%s_valid_off", name), {127'b0, kif.rk_valid}, 128'd0);
        tick();
        check($sformatf("%s_done_clear", name), {127'b0, kif.done}, 128'd0);
        check($sformatf("%s_start_ignored", name), {127'b0, kif.rk_valid}, 128'd0);
    endtask

    initial begin
        logic [127:0] k0;
        rst_n        = 1'b0;
        kif.start    = 1'b0;
        kif.rk_ready = 1'b0;
        kif.key_last = '0;
        build_sbox();
        tick();
        tick();
        check("reset_valid", {127'b0, kif.rk_valid}, 128'd0);
        check("reset_busy", {127'b0, kif.busy}, 128'd0);
        check("reset_done", {127'b0, kif.done}, 128'd0);
        check("reset_round", {124'b0, kif.rk_round}, 128'd0);
        check("reset_data", kif.rk_data, 128'd0);
        check("reset_rcon", {120'b0, dut.rcon_reg}, 128'h36);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_seq("fips", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, -1, -1);
        check("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_r9", obs_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        check("fips_r0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        run_seq("bp", exp_rk[10], 5, -1, -1);
        run_seq("inj", exp_rk[10], -1, 7, -1);
        run_seq("rst", exp_rk[10], -1, -1, 3);
        run_seq("after_rst", exp_rk[10], -1, -1, -1);
        run_seq("b2b", exp_rk[10], -1, -1, -1);
        check("b2b_r0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        for (int n = 0; n < 4; n++) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            expand(k0);
            run_seq($sformatf("rnd%0d", n), exp_rk[10], int'($urandom_range(0, 10)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
